pipeline_exb_stage_p: RTL and testbench

- Parametrised branch-resolution stage, the next generation of the 5-stage EXB stage.
- Sits between IDR and EXA.
- Resolves conditional branches, JAL and JALR. Compares the outcome against the fetch-stage prediction and raises a one-cycle redirect only on misprediction.
- Flags misaligned targets, keeps saturating branch/mispredict counters, and registers the instruction into EXA with a valid bit.

---
 rtl/exb_pkg.sv | 23 ++
 rtl/branch_cmp_p.sv | 32 +++
 rtl/pipeline_exb_stage_p.sv | 127 ++++++++++++
 tb/tb_pipeline_exb_stage_p.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/exb_pkg.sv
// Shared types and helpers for the EXB branch-resolution stage.
package exb_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_type_e;

    localparam int XLEN_DEF   = 64;
    localparam int IALIGN_DEF = 4;

    // Saturating +1 on a counter of width w (w <= 64), carried in a 64-bit container.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/branch_cmp_p.sv
// Branch condition evaluator; reserved encodings 010/011 resolve not-taken.
module branch_cmp_p
    import exb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      br_type,
    output logic            cond
);

    logic eq, lt, ltu;

    assign eq  = (a == b);
    assign lt  = ($signed(a) < $signed(b));
    assign ltu = (a < b);

    always_comb begin
        cond = 1'b0;
        case (br_type_e'(br_type))
            BEQ:     cond = eq;
            BNE:     cond = ~eq;
            BLT:     cond = lt;
            BGE:     cond = ~lt;
            BLTU:    cond = ltu;
            BGEU:    cond = ~ltu;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipeline_exb_stage_p.sv
// EXB stage: resolves branches/jumps against the fetch prediction, redirects on
// mispredict, and registers the instruction into EXA.
module pipeline_exb_stage_p
    import exb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32,
    parameter int IALIGN = IALIGN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              stall,
    input  logic              valid_IDR,
    input  logic [XLEN-1:0]   pc_IDR,
    input  logic [XLEN-1:0]   reg_data1_IDR,
    input  logic [XLEN-1:0]   reg_data2_IDR,
    input  logic [XLEN-1:0]   imm_IDR,
    input  logic [CTRL_W-1:0] ctrl_IDR,
    input  logic              is_branch_IDR,
    input  logic              do_jump_IDR,
    input  logic              is_jalr_IDR,
    input  logic [2:0]        BrType_IDR,
    input  logic              pred_taken_IDR,
    input  logic [XLEN-1:0]   pred_target_IDR,
    output logic              branch_taken_EXB,
    output logic [XLEN-1:0]   branch_target_EXB,
    output logic              redirect_EXB,
    output logic [XLEN-1:0]   redirect_pc_EXB,
    output logic              valid_EXB,
    output logic [XLEN-1:0]   pc_EXB,
    output logic [XLEN-1:0]   reg_data1_EXB,
    output logic [XLEN-1:0]   reg_data2_EXB,
    output logic [XLEN-1:0]   imm_EXB,
    output logic [CTRL_W-1:0] ctrl_EXB,
    output logic [XLEN-1:0]   link_pc_EXB,
    output logic              misalign_EXB,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
    localparam logic [XLEN-1:0] LINK_INC   = XLEN'(IALIGN);

    logic            cmp_cond, cond, taken, fire, resolve, mispredict, misalign;
    logic [XLEN-1:0] target, link_pc;

    branch_cmp_p #(.XLEN(XLEN)) u_cmp (
        .a       (reg_data1_IDR),
        .b       (reg_data2_IDR),
        .br_type (BrType_IDR),
        .cond    (cmp_cond)
    );

    assign cond    = cmp_cond & is_branch_IDR;
    assign taken   = cond | do_jump_IDR;
    assign target  = is_jalr_IDR ? ((reg_data1_IDR + imm_IDR) & ~XLEN'(1))
                                 : (pc_IDR + imm_IDR);
    assign link_pc = pc_IDR + LINK_INC;

    assign fire       = valid_IDR & ~stall & ~flush & reset;
    assign resolve    = fire & (is_branch_IDR | do_jump_IDR);
    assign mispredict = (taken != pred_taken_IDR)
                      | (taken & pred_taken_IDR & (target != pred_target_IDR));
    assign misalign   = taken & (|(target & ALIGN_MASK));

    assign branch_taken_EXB  = taken & fire;
    assign branch_target_EXB = target;
    assign redirect_pc_EXB   = taken ? target : link_pc;
    // Gated by fire rather than resolve so a non-control instruction that fetch
    // predicted taken still steers fetch back to pc+IALIGN.
    assign redirect_EXB      = fire & mispredict;

    logic              valid_q, misalign_q;
    logic [XLEN-1:0]   pc_q, rd1_q, rd2_q, imm_q, link_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [CNT_W-1:0]  br_cnt_q, mp_cnt_q, br_cnt_d, mp_cnt_d;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            pc_q       <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            link_q     <= '0;
            ctrl_q     <= '0;
        end else if (!stall) begin
            valid_q    <= valid_IDR;
            misalign_q <= misalign & valid_IDR;
            pc_q       <= pc_IDR;
            rd1_q      <= reg_data1_IDR;
            rd2_q      <= reg_data2_IDR;
            imm_q      <= imm_IDR;
            link_q     <= link_pc;
            ctrl_q     <= ctrl_IDR;
        end
    end

    assign br_cnt_d = CNT_W'(sat_inc(64'(br_cnt_q), CNT_W));
    assign mp_cnt_d = CNT_W'(sat_inc(64'(mp_cnt_q), CNT_W));

    // fire already folds in flush and stall, so counters hold in those cases.
    always_ff @(posedge clk) begin
        if (!reset) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            if (resolve)           br_cnt_q <= br_cnt_d;
            if (fire & mispredict) mp_cnt_q <= mp_cnt_d;
        end
    end

    assign valid_EXB     = valid_q;
    assign misalign_EXB  = misalign_q;
    assign pc_EXB        = pc_q;
    assign reg_data1_EXB = rd1_q;
    assign reg_data2_EXB = rd2_q;
    assign imm_EXB       = imm_q;
    assign link_pc_EXB   = link_q;
    assign ctrl_EXB      = ctrl_q;
    assign br_cnt        = br_cnt_q;
    assign mispred_cnt   = mp_cnt_q;

endmodule

// File: tb/tb_pipeline_exb_stage_p.sv
// Directed bench for the EXB stage; a second instance with CNT_W=2 covers saturation.
module tb_pipeline_exb_stage_p;

    logic        clk = 1'b0;
    logic        reset, flush, stall, valid_IDR;
    logic [63:0] pc_IDR, reg_data1_IDR, reg_data2_IDR, imm_IDR, pred_target_IDR;
    logic [15:0] ctrl_IDR;
    logic        is_branch_IDR, do_jump_IDR, is_jalr_IDR, pred_taken_IDR;
    logic [2:0]  BrType_IDR;

    logic        branch_taken_EXB, redirect_EXB, valid_EXB, misalign_EXB;
    logic [63:0] branch_target_EXB, redirect_pc_EXB, pc_EXB, reg_data1_EXB;
    logic [63:0] reg_data2_EXB, imm_EXB, link_pc_EXB;
    logic [15:0] ctrl_EXB;
    logic [31:0] br_cnt, mispred_cnt;

    logic        s_taken, s_redirect, s_valid, s_misalign;
    logic [63:0] s_target, s_rpc, s_pc, s_rd1, s_rd2, s_imm, s_link;
    logic [15:0] s_ctrl;
    logic [1:0]  s_br_cnt, s_mp_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_exb_stage_p #(.XLEN(64), .CTRL_W(16), .CNT_W(32), .IALIGN(4)) dut (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall), .valid_IDR(valid_IDR),
        .pc_IDR(pc_IDR), .reg_data1_IDR(reg_data1_IDR), .reg_data2_IDR(reg_data2_IDR),
        .imm_IDR(imm_IDR), .ctrl_IDR(ctrl_IDR), .is_branch_IDR(is_branch_IDR),
        .do_jump_IDR(do_jump_IDR), .is_jalr_IDR(is_jalr_IDR), .BrType_IDR(BrType_IDR),
        .pred_taken_IDR(pred_taken_IDR), .pred_target_IDR(pred_target_IDR),
        .branch_taken_EXB(branch_taken_EXB), .branch_target_EXB(branch_target_EXB),
        .redirect_EXB(redirect_EXB), .redirect_pc_EXB(redirect_pc_EXB),
        .valid_EXB(valid_EXB), .pc_EXB(pc_EXB), .reg_data1_EXB(reg_data1_EXB),
        .reg_data2_EXB(reg_data2_EXB), .imm_EXB(imm_EXB), .ctrl_EXB(ctrl_EXB),
        .link_pc_EXB(link_pc_EXB), .misalign_EXB(misalign_EXB),
        .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
    );

    pipeline_exb_stage_p #(.XLEN(64), .CTRL_W(16), .CNT_W(2), .IALIGN(4)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall), .valid_IDR(valid_IDR),
        .pc_IDR(pc_IDR), .reg_data1_IDR(reg_data1_IDR), .reg_data2_IDR(reg_data2_IDR),
        .imm_IDR(imm_IDR), .ctrl_IDR(ctrl_IDR), .is_branch_IDR(is_branch_IDR),
        .do_jump_IDR(do_jump_IDR), .is_jalr_IDR(is_jalr_IDR), .BrType_IDR(BrType_IDR),
        .pred_taken_IDR(pred_taken_IDR), .pred_target_IDR(pred_target_IDR),
        .branch_taken_EXB(s_taken), .branch_target_EXB(s_target),
        .redirect_EXB(s_redirect), .redirect_pc_EXB(s_rpc),
        .valid_EXB(s_valid), .pc_EXB(s_pc), .reg_data1_EXB(s_rd1),
        .reg_data2_EXB(s_rd2), .imm_EXB(s_imm), .ctrl_EXB(s_ctrl),
        .link_pc_EXB(s_link), .misalign_EXB(s_misalign),
        .br_cnt(s_br_cnt), .mispred_cnt(s_mp_cnt)
    );

    task automatic set_in(input logic v, input logic [63:0] pc, r1, r2, imm,
                          input logic isb, jmp, jalr, input logic [2:0] bt,
                          input logic pt, input logic [63:0] ptg);
        valid_IDR = v; pc_IDR = pc; reg_data1_IDR = r1; reg_data2_IDR = r2; imm_IDR = imm;
        is_branch_IDR = isb; do_jump_IDR = jmp; is_jalr_IDR = jalr; BrType_IDR = bt;
        pred_taken_IDR = pt; pred_target_IDR = ptg;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        ctrl_IDR = 16'hBEEF;
        set_in(1'b1, 64'h1000, 64'd5, 64'd5, 64'h40, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (branch_taken_EXB !== 1'b0) begin errors++; $display("FAIL rst_taken got %0h exp 0", branch_taken_EXB); end
        checks++; if (redirect_EXB !== 1'b0) begin errors++; $display("FAIL rst_redirect got %0h exp 0", redirect_EXB); end
        checks++; if (valid_EXB !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", valid_EXB); end
        checks++; if (pc_EXB !== 64'h0) begin errors++; $display("FAIL rst_pc got %0h exp 0", pc_EXB); end
        checks++; if (link_pc_EXB !== 64'h0) begin errors++; $display("FAIL rst_link got %0h exp 0", link_pc_EXB); end
        checks++; if (ctrl_EXB !== 16'h0) begin errors++; $display("FAIL rst_ctrl got %0h exp 0", ctrl_EXB); end
        checks++; if (misalign_EXB !== 1'b0) begin errors++; $display("FAIL rst_misalign got %0h exp 0", misalign_EXB); end
        checks++; if (br_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", br_cnt, mispred_cnt); end
        reset = 1'b1;
    endtask

    task automatic test_beq();
        ctrl_IDR = 16'h1234;
        set_in(1'b1, 64'h1000, 64'd5, 64'd5, 64'h40, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'h0);
        #1;
        checks++; if (branch_taken_EXB !== 1'b1) begin errors++; $display("FAIL beq_taken got %0h exp 1", branch_taken_EXB); end
        checks++; if (branch_target_EXB !== 64'h1040) begin errors++; $display("FAIL beq_target got %0h exp 1040", branch_target_EXB); end
        checks++; if (redirect_EXB !== 1'b1) begin errors++; $display("FAIL beq_redirect got %0h exp 1", redirect_EXB); end
        checks++; if (redirect_pc_EXB !== 64'h1040) begin errors++; $display("FAIL beq_rpc got %0h exp 1040", redirect_pc_EXB); end
        step();
        checks++; if (valid_EXB !== 1'b1) begin errors++; $display("FAIL beq_valid got %0h exp 1", valid_EXB); end
        checks++; if (link_pc_EXB !== 64'h1004) begin errors++; $display("FAIL beq_link got %0h exp 1004", link_pc_EXB); end
        checks++; if (pc_EXB !== 64'h1000 || imm_EXB !== 64'h40) begin errors++; $display("FAIL beq_pc_imm got %0h/%0h exp 1000/40", pc_EXB, imm_EXB); end
        checks++; if (reg_data1_EXB !== 64'd5 || reg_data2_EXB !== 64'd5) begin errors++; $display("FAIL beq_rd got %0h/%0h exp 5/5", reg_data1_EXB, reg_data2_EXB); end
        checks++; if (ctrl_EXB !== 16'h1234) begin errors++; $display("FAIL beq_ctrl got %0h exp 1234", ctrl_EXB); end
        checks++; if (misalign_EXB !== 1'b0) begin errors++; $display("FAIL beq_misalign got %0h exp 0", misalign_EXB); end
        checks++; if (br_cnt !== 32'd1 || mispred_cnt !== 32'd1) begin errors++; $display("FAIL beq_cnt got %0d/%0d exp 1/1", br_cnt, mispred_cnt); end
    endtask

    task automatic test_signed_unsigned();
        set_in(1'b1, 64'h2000, 64'd1, {64{1'b1}}, 64'h40, 1'b1, 1'b0, 1'b0, 3'b110, 1'b1, 64'h2040);
        #1;
        checks++; if (branch_taken_EXB !== 1'b1) begin errors++; $display("FAIL bltu_taken got %0h exp 1", branch_taken_EXB); end
        checks++; if (redirect_EXB !== 1'b0) begin errors++; $display("FAIL bltu_redirect got %0h exp 0", redirect_EXB); end
        step();
        checks++; if (br_cnt !== 32'd2 || mispred_cnt !== 32'd1) begin errors++; $display("FAIL bltu_cnt got %0d/%0d exp 2/1", br_cnt, mispred_cnt); end
        BrType_IDR = 3'b100;
        #1;
        checks++; if (branch_taken_EXB !== 1'b0) begin errors++; $display("FAIL blt_taken got %0h exp 0", branch_taken_EXB); end
        checks++; if (redirect_EXB !== 1'b1) begin errors++; $display("FAIL blt_redirect got %0h exp 1", redirect_EXB); end
        checks++; if (redirect_pc_EXB !== 64'h2004) begin errors++; $display("FAIL blt_rpc got %0h exp 2004", redirect_pc_EXB); end
        step();
        checks++; if (br_cnt !== 32'd3 || mispred_cnt !== 32'd2) begin errors++; $display("FAIL blt_cnt got %0d/%0d exp 3/2", br_cnt, mispred_cnt); end
    endtask

    task automatic test_jumps();
        set_in(1'b1, 64'h3000, 64'h3001, 64'h0, 64'h10, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 64'h0);
        #1;
        checks++; if (branch_target_EXB !== 64'h3010) begin errors++; $display("FAIL jalr_target got %0h exp 3010", branch_target_EXB); end
        checks++; if (redirect_EXB !== 1'b1 || redirect_pc_EXB !== 64'h3010) begin errors++; $display("FAIL jalr_redirect got %0h/%0h exp 1/3010", redirect_EXB, redirect_pc_EXB); end
        step();
        checks++; if (misalign_EXB !== 1'b0) begin errors++; $display("FAIL jalr_misalign got %0h exp 0", misalign_EXB); end
        checks++; if (link_pc_EXB !== 64'h3004) begin errors++; $display("FAIL jalr_link got %0h exp 3004", link_pc_EXB); end
        set_in(1'b1, 64'h4000, 64'h0, 64'h0, 64'h6, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 64'h4006);
        #1;
        checks++; if (branch_target_EXB !== 64'h4006) begin errors++; $display("FAIL jal_target got %0h exp 4006", branch_target_EXB); end
        checks++; if (redirect_EXB !== 1'b0) begin errors++; $display("FAIL jal_redirect got %0h exp 0", redirect_EXB); end
        step();
        checks++; if (misalign_EXB !== 1'b1) begin errors++; $display("FAIL jal_misalign got %0h exp 1", misalign_EXB); end
        checks++; if (br_cnt !== 32'd5 || mispred_cnt !== 32'd3) begin errors++; $display("FAIL jump_cnt got %0d/%0d exp 5/3", br_cnt, mispred_cnt); end
    endtask

    task automatic test_nonctrl();
        set_in(1'b1, 64'h4100, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 64'h5000);
        #1;
        checks++; if (redirect_EXB !== 1'b1 || redirect_pc_EXB !== 64'h4104) begin errors++; $display("FAIL nonctrl_redirect got %0h/%0h exp 1/4104", redirect_EXB, redirect_pc_EXB); end
        step();
        checks++; if (br_cnt !== 32'd5 || mispred_cnt !== 32'd4) begin errors++; $display("FAIL nonctrl_cnt got %0d/%0d exp 5/4", br_cnt, mispred_cnt); end
        set_in(1'b1, 64'h4200, 64'd3, 64'd3, 64'h20, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 64'h0);
        #1;
        checks++; if (branch_taken_EXB !== 1'b0 || redirect_EXB !== 1'b0) begin errors++; $display("FAIL rsvd_enc got %0h/%0h exp 0/0", branch_taken_EXB, redirect_EXB); end
        step();
        checks++; if (br_cnt !== 32'd6 || mispred_cnt !== 32'd4) begin errors++; $display("FAIL rsvd_cnt got %0d/%0d exp 6/4", br_cnt, mispred_cnt); end
    endtask

    task automatic test_stall_flush();
        set_in(1'b1, 64'h5000, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 64'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (redirect_EXB !== 1'b0 || branch_taken_EXB !== 1'b0) begin errors++; $display("FAIL stall_redirect[%0d] got %0h/%0h exp 0/0", i, redirect_EXB, branch_taken_EXB); end
            step();
            checks++; if (pc_EXB !== 64'h4200 || br_cnt !== 32'd6) begin errors++; $display("FAIL stall_hold[%0d] got %0h/%0d exp 4200/6", i, pc_EXB, br_cnt); end
        end
        stall = 1'b0;
        #1;
        checks++; if (redirect_EXB !== 1'b1 || redirect_pc_EXB !== 64'h4FF8) begin errors++; $display("FAIL unstall_redirect got %0h/%0h exp 1/4ff8", redirect_EXB, redirect_pc_EXB); end
        step();
        valid_IDR = 1'b0;
        #1;
        checks++; if (redirect_EXB !== 1'b0) begin errors++; $display("FAIL redirect_once got %0h exp 0", redirect_EXB); end
        checks++; if (pc_EXB !== 64'h5000 || br_cnt !== 32'd7 || mispred_cnt !== 32'd5) begin errors++; $display("FAIL unstall_load got %0h/%0d/%0d exp 5000/7/5", pc_EXB, br_cnt, mispred_cnt); end
        step();
        checks++; if (valid_EXB !== 1'b0) begin errors++; $display("FAIL bubble_valid got %0h exp 0", valid_EXB); end
        set_in(1'b1, 64'h5100, 64'd1, 64'd2, 64'h8, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 64'h0);
        flush = 1'b1; stall = 1'b1;
        #1;
        checks++; if (redirect_EXB !== 1'b0) begin errors++; $display("FAIL flush_redirect got %0h exp 0", redirect_EXB); end
        step();
        checks++; if (valid_EXB !== 1'b0 || pc_EXB !== 64'h0) begin errors++; $display("FAIL flush_regs got %0h/%0h exp 0/0", valid_EXB, pc_EXB); end
        checks++; if (br_cnt !== 32'd7 || mispred_cnt !== 32'd5) begin errors++; $display("FAIL flush_cnt got %0d/%0d exp 7/5", br_cnt, mispred_cnt); end
        flush = 1'b0; stall = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_in(1'b1, 64'h5200, 64'd4, 64'd4, 64'h10, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 64'h0);
        step();
        reset = 1'b0;
        #1;
        checks++; if (branch_taken_EXB !== 1'b0 || redirect_EXB !== 1'b0) begin errors++; $display("FAIL midrst_comb got %0h/%0h exp 0/0", branch_taken_EXB, redirect_EXB); end
        step();
        checks++; if (valid_EXB !== 1'b0 || pc_EXB !== 64'h0 || link_pc_EXB !== 64'h0) begin errors++; $display("FAIL midrst_regs got %0h/%0h/%0h exp 0/0/0", valid_EXB, pc_EXB, link_pc_EXB); end
        checks++; if (br_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin errors++; $display("FAIL midrst_cnt got %0d/%0d exp 0/0", br_cnt, mispred_cnt); end
        reset = 1'b1;
        set_in(1'b1, 64'h6000, 64'd7, 64'd7, 64'h8, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 64'h6008);
        step();
        checks++; if (valid_EXB !== 1'b1 || pc_EXB !== 64'h6000 || link_pc_EXB !== 64'h6004) begin errors++; $display("FAIL postrst_load got %0h/%0h/%0h exp 1/6000/6004", valid_EXB, pc_EXB, link_pc_EXB); end
        checks++; if (br_cnt !== 32'd1 || mispred_cnt !== 32'd0) begin errors++; $display("FAIL postrst_cnt got %0d/%0d exp 1/0", br_cnt, mispred_cnt); end
    endtask

    task automatic test_saturate();
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 64'h7000 + 64'(i * 4), 64'd1, 64'd2, 64'h10, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 64'h0);
            step();
        end
        checks++; if (s_br_cnt !== 2'd3 || s_mp_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt got %0d/%0d exp 3/3", s_br_cnt, s_mp_cnt); end
        checks++; if (br_cnt !== 32'd5 || mispred_cnt !== 32'd5) begin errors++; $display("FAIL wide_cnt got %0d/%0d exp 5/5", br_cnt, mispred_cnt); end
        valid_IDR = 1'b0;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; stall = 1'b0; ctrl_IDR = 16'h0;
        set_in(1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 64'h0);
        test_reset();
        test_beq();
        test_signed_unsigned();
        test_jumps();
        test_nonctrl();
        test_stall_flush();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
